tex_bilerp_pipe: RTL and testbench

Pipelined bilinear filter stage of the texture unit. Takes four fetched texels per request plus fixed-point u/v fractions, blends them per channel, rounds, and adds an optional signed bias. Emits signed results two bits wider than the channel width plus sign, ready for the downstream texture saturation stage to clamp back to CHAN_W. Sits between the texel-fetch return path and the saturator/format-pack stage, with valid/ready handshakes on both sides.

---
 rtl/tex_bilerp_pipe_pkg.sv | 23 ++
 rtl/tex_lerp.sv | 31 +++
 rtl/tex_bilerp_pipe.sv | 197 +++++++++++++++++++
 tb/tb_tex_bilerp_pipe.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tex_bilerp_pipe_pkg.sv
// tex_bilerp_pipe_pkg
//   Shared definitions for the texture bilinear filter:
//   - T00..T11 : texel slot indices inside a request (index = 2*v + u)
//   - tex_frac_t : u/v fraction type at the default fraction width
//   - tex_res_w() : width of one signed blended result channel
package tex_bilerp_pipe_pkg;

  localparam int unsigned T00 = 0;
  localparam int unsigned T01 = 1;
  localparam int unsigned T10 = 2;
  localparam int unsigned T11 = 3;

  localparam int unsigned TEX_FRAC_W = 8;

  typedef logic [TEX_FRAC_W-1:0] tex_frac_t;

  // Rounded channel plus a sign-extended (CHAN_W+1)-bit bias never
  // exceeds CHAN_W+3 signed bits.
  function automatic int unsigned tex_res_w(input int unsigned chan_w);
    return chan_w + 3;
  endfunction

endpackage

// File: rtl/tex_lerp.sv
// tex_lerp
//   Combinational two-input blend: z = x*(2^FRAC_W - w) + y*w.
//   The result is exact; it always fits IN_W+FRAC_W bits.
// Ports:
//   x, y : IN_W-bit unsigned inputs
//   w    : FRAC_W-bit unsigned weight (value / 2^FRAC_W)
//   z    : IN_W+FRAC_W-bit unsigned blend
module tex_lerp
  import tex_bilerp_pipe_pkg::*;
#(
  parameter int unsigned IN_W   = 8,
  parameter int unsigned FRAC_W = TEX_FRAC_W
) (
  input  logic [IN_W-1:0]        x,
  input  logic [IN_W-1:0]        y,
  input  logic [FRAC_W-1:0]      w,
  output logic [IN_W+FRAC_W-1:0] z
);

  localparam int unsigned ZW = IN_W + FRAC_W;
  localparam logic [FRAC_W:0] ONE = {1'b1, {FRAC_W{1'b0}}};

  logic [FRAC_W:0] w_inv;

  // Evaluated modulo 2^ZW; the true sum is below 2^ZW so nothing is lost.
  always_comb begin
    w_inv = ONE - {1'b0, w};
    z     = ZW'(x) * ZW'(w_inv) + ZW'(y) * ZW'(w);
  end

endmodule

// File: rtl/tex_bilerp_pipe.sv
// tex_bilerp_pipe
//   Three-stage pipelined bilinear filter with valid/ready on both sides.
//     stage 1 : horizontal blends h0 = lerp(t00,t01,a), h1 = lerp(t10,t11,a)
//     stage 2 : vertical blend v = lerp(h0,h1,b)
//     stage 3 : round v by 2*FRAC_W bits, optionally add signed bias
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   req_valid/ready   : request handshake (ready is combinational from rsp_ready)
//   req_texels        : t00,t01,t10,t11 from LSB, channel-major within texel
//   req_alpha/beta    : u / v fractions
//   req_bias          : signed per-channel bias (CHAN_W+1 bits each)
//   req_tag           : opaque tag, returned on rsp_tag
//   rsp_valid/ready   : response handshake
//   rsp_data          : signed per-channel results (CHAN_W+3 bits each)
//   perf_stalls       : saturating count of rsp_valid & ~rsp_ready cycles
// Build option:
//   TEX_BILERP_BIAS_EN : when defined, bias is carried and added in stage 3;
//                        otherwise req_bias is ignored and not registered.
module tex_bilerp_pipe
  import tex_bilerp_pipe_pkg::*;
#(
  parameter int unsigned CHAN_W   = 8,
  parameter int unsigned NUM_CHAN = 4,
  parameter int unsigned FRAC_W   = 8,
  parameter int unsigned TAG_W    = 8
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    req_valid,
  output logic                                    req_ready,
  input  logic [4*NUM_CHAN*CHAN_W-1:0]            req_texels,
  input  logic [FRAC_W-1:0]                       req_alpha,
  input  logic [FRAC_W-1:0]                       req_beta,
  input  logic [NUM_CHAN*(CHAN_W+1)-1:0]          req_bias,
  input  logic [TAG_W-1:0]                        req_tag,
  output logic                                    rsp_valid,
  input  logic                                    rsp_ready,
  output logic [NUM_CHAN*tex_res_w(CHAN_W)-1:0]   rsp_data,
  output logic [TAG_W-1:0]                        rsp_tag,
  output logic [31:0]                             perf_stalls
);

  localparam int unsigned RES_W  = tex_res_w(CHAN_W);
  localparam int unsigned BIAS_W = CHAN_W + 1;
  localparam int unsigned HW     = CHAN_W + FRAC_W;
  localparam int unsigned VW     = CHAN_W + 2 * FRAC_W;
  localparam logic [VW-1:0] HALF = VW'(1) << (2 * FRAC_W - 1);

  // Stage enables: a stage loads when empty or when its contents move on.
  logic s1_en, s2_en, s3_en;

  logic                                s1_valid_q, s1_valid_d;
  logic [NUM_CHAN-1:0][HW-1:0]         h0_c, h1_c;
  logic [NUM_CHAN-1:0][HW-1:0]         h0_q, h0_d, h1_q, h1_d;
  logic [FRAC_W-1:0]                   beta1_q, beta1_d;
  logic [TAG_W-1:0]                    tag1_q, tag1_d;

  logic                                s2_valid_q, s2_valid_d;
  logic [NUM_CHAN-1:0][VW-1:0]         v_c;
  logic [NUM_CHAN-1:0][VW-1:0]         v_q, v_d;
  logic [TAG_W-1:0]                    tag2_q, tag2_d;

  logic                                s3_valid_q, s3_valid_d;
  logic [NUM_CHAN-1:0][VW-1:0]         rnd_sum;
  logic [NUM_CHAN-1:0][CHAN_W-1:0]     rnd_r;
  logic [NUM_CHAN-1:0][RES_W-1:0]      out_c;
  logic [NUM_CHAN-1:0][RES_W-1:0]      out_q, out_d;
  logic [TAG_W-1:0]                    tag3_q, tag3_d;

  logic [31:0]                         perf_q, perf_d;

`ifdef TEX_BILERP_BIAS_EN
  logic [NUM_CHAN-1:0][BIAS_W-1:0]     bias1_q, bias1_d;
  logic [NUM_CHAN-1:0][BIAS_W-1:0]     bias2_q, bias2_d;
`else
  logic                                unused_bias;
  assign unused_bias = ^req_bias;
`endif

  for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
    tex_lerp #(.IN_W(CHAN_W), .FRAC_W(FRAC_W)) u_h0 (
      .x (req_texels[(T00 * NUM_CHAN + c) * CHAN_W +: CHAN_W]),
      .y (req_texels[(T01 * NUM_CHAN + c) * CHAN_W +: CHAN_W]),
      .w (req_alpha),
      .z (h0_c[c])
    );
    tex_lerp #(.IN_W(CHAN_W), .FRAC_W(FRAC_W)) u_h1 (
      .x (req_texels[(T10 * NUM_CHAN + c) * CHAN_W +: CHAN_W]),
      .y (req_texels[(T11 * NUM_CHAN + c) * CHAN_W +: CHAN_W]),
      .w (req_alpha),
      .z (h1_c[c])
    );
    tex_lerp #(.IN_W(HW), .FRAC_W(FRAC_W)) u_v (
      .x (h0_q[c]),
      .y (h1_q[c]),
      .w (beta1_q),
      .z (v_c[c])
    );
  end

  // Round-half-up and optional bias; v + HALF cannot overflow VW bits.
  always_comb begin
    rnd_sum = '0;
    rnd_r   = '0;
    out_c   = '0;
    for (int unsigned c = 0; c < NUM_CHAN; c++) begin
      rnd_sum[c] = v_q[c] + HALF;
      rnd_r[c]   = CHAN_W'(rnd_sum[c] >> (2 * FRAC_W));
`ifdef TEX_BILERP_BIAS_EN
      out_c[c]   = {{(RES_W - CHAN_W){1'b0}}, rnd_r[c]}
                 + {{(RES_W - BIAS_W){bias2_q[c][BIAS_W-1]}}, bias2_q[c]};
`else
      out_c[c]   = {{(RES_W - CHAN_W){1'b0}}, rnd_r[c]};
`endif
    end
  end

  always_comb begin
    s3_en = ~s3_valid_q | rsp_ready;
    s2_en = ~s2_valid_q | s3_en;
    s1_en = ~s1_valid_q | s2_en;

    s1_valid_d = s1_en ? req_valid  : s1_valid_q;
    h0_d       = s1_en ? h0_c       : h0_q;
    h1_d       = s1_en ? h1_c       : h1_q;
    beta1_d    = s1_en ? req_beta   : beta1_q;
    tag1_d     = s1_en ? req_tag    : tag1_q;

    s2_valid_d = s2_en ? s1_valid_q : s2_valid_q;
    v_d        = s2_en ? v_c        : v_q;
    tag2_d     = s2_en ? tag1_q     : tag2_q;

    s3_valid_d = s3_en ? s2_valid_q : s3_valid_q;
    out_d      = s3_en ? out_c      : out_q;
    tag3_d     = s3_en ? tag2_q     : tag3_q;

`ifdef TEX_BILERP_BIAS_EN
    bias1_d = bias1_q;
    if (s1_en) begin
      for (int unsigned c = 0; c < NUM_CHAN; c++) begin
        bias1_d[c] = req_bias[c * BIAS_W +: BIAS_W];
      end
    end
    bias2_d = s2_en ? bias1_q : bias2_q;
`endif

    perf_d = perf_q;
    if (s3_valid_q && !rsp_ready && perf_q != '1) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      h0_q       <= '0;
      h1_q       <= '0;
      beta1_q    <= '0;
      tag1_q     <= '0;
      s2_valid_q <= 1'b0;
      v_q        <= '0;
      tag2_q     <= '0;
      s3_valid_q <= 1'b0;
      out_q      <= '0;
      tag3_q     <= '0;
      perf_q     <= '0;
`ifdef TEX_BILERP_BIAS_EN
      bias1_q    <= '0;
      bias2_q    <= '0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      h0_q       <= h0_d;
      h1_q       <= h1_d;
      beta1_q    <= beta1_d;
      tag1_q     <= tag1_d;
      s2_valid_q <= s2_valid_d;
      v_q        <= v_d;
      tag2_q     <= tag2_d;
      s3_valid_q <= s3_valid_d;
      out_q      <= out_d;
      tag3_q     <= tag3_d;
      perf_q     <= perf_d;
`ifdef TEX_BILERP_BIAS_EN
      bias1_q    <= bias1_d;
      bias2_q    <= bias2_d;
`endif
    end
  end

  assign req_ready   = s1_en;
  assign rsp_valid   = s3_valid_q;
  assign rsp_data    = out_q;
  assign rsp_tag     = tag3_q;
  assign perf_stalls = perf_q;

endmodule

// File: tb/tb_tex_bilerp_pipe.sv
// tb_tex_bilerp_pipe
//   Randomized and directed stimulus for tex_bilerp_pipe, checked against an
//   arithmetic reference model and an in-order expectation queue.
module tb_tex_bilerp_pipe;
  import tex_bilerp_pipe_pkg::*;

  localparam int CW = 8;
  localparam int NC = 4;
  localparam int FW = 8;
  localparam int TW = 8;
  localparam int RW = CW + 3;
  localparam int BW = CW + 1;
  localparam int DW = NC * RW;
  localparam int XW = 4 * NC * CW;
  localparam int QW = NC * BW;
`ifdef TEX_BILERP_BIAS_EN
  localparam bit BIAS_EN = 1'b1;
`else
  localparam bit BIAS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [XW-1:0] req_texels = '0;
  tex_frac_t     req_alpha = '0;
  tex_frac_t     req_beta = '0;
  logic [QW-1:0] req_bias = '0;
  logic [TW-1:0] req_tag = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic [TW-1:0] rsp_tag;
  logic [31:0]   perf_stalls;

  int tests_run = 0;
  int tests_failed = 0;
  int rdy_mode = 0;       // 0: ready, 1: toggle, 2: held low, 3: random
  int model_stalls = 0;
  int rsp_seen = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic [TW-1:0] t;
  } exp_t;
  exp_t exp_q[$];

  tex_bilerp_pipe #(.CHAN_W(CW), .NUM_CHAN(NC), .FRAC_W(FW), .TAG_W(TW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_texels  (req_texels),
    .req_alpha   (req_alpha),
    .req_beta    (req_beta),
    .req_bias    (req_bias),
    .req_tag     (req_tag),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_tag     (rsp_tag),
    .perf_stalls (perf_stalls)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bilinear blend computed directly from the filter equations.
  function automatic logic [DW-1:0] model_rsp(input logic [XW-1:0] tx, input logic [FW-1:0] a,
                                              input logic [FW-1:0] b, input logic [QW-1:0] bias);
    logic [DW-1:0] res;
    longint t[4];
    longint one, h0, h1, v, r, bv;
    logic [RW-1:0] o;
    res = '0;
    one = longint'(1) << FW;
    for (int c = 0; c < NC; c++) begin
      for (int k = 0; k < 4; k++) t[k] = longint'(tx[(k * NC + c) * CW +: CW]);
      h0 = t[0] * (one - longint'(a)) + t[1] * longint'(a);
      h1 = t[2] * (one - longint'(a)) + t[3] * longint'(a);
      v  = h0 * (one - longint'(b)) + h1 * longint'(b);
      r  = (v + (longint'(1) << (2 * FW - 1))) >> (2 * FW);
      bv = BIAS_EN ? longint'($signed(bias[c * BW +: BW])) : 0;
      o  = RW'(r + bv);
      res[c * RW +: RW] = o;
    end
    return res;
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: rsp_ready = 1'b1;
      1: rsp_ready = ~rsp_ready;
      2: rsp_ready = 1'b0;
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Scoreboard: sampled mid-cycle; handshakes seen here complete at the next edge.
  logic          held = 1'b0;
  logic [DW-1:0] held_d;
  logic [TW-1:0] held_t;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      exp_q.delete();
      model_stalls = 0;
      held = 1'b0;
    end else begin
      if (held) begin
        check_eq("hold_valid", 64'(rsp_valid), 64'(1));
        check_eq("hold_data", 64'(rsp_data), 64'(held_d));
        check_eq("hold_tag", 64'(rsp_tag), 64'(held_t));
      end
      held   = rsp_valid && !rsp_ready;
      held_d = rsp_data;
      held_t = rsp_tag;
      if (rsp_valid && !rsp_ready) model_stalls++;
      if (rsp_valid && rsp_ready) begin
        rsp_seen++;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_rsp", 64'(rsp_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check_eq("rsp_data", 64'(rsp_data), 64'(e.d));
          check_eq("rsp_tag", 64'(rsp_tag), 64'(e.t));
        end
      end
      if (req_valid && req_ready) begin
        e.d = model_rsp(req_texels, req_alpha, req_beta, req_bias);
        e.t = req_tag;
        exp_q.push_back(e);
      end
    end
  end

  task automatic rand_req(input logic [TW-1:0] tag);
    logic [63:0] b64;
    req_texels = {$urandom(), $urandom(), $urandom(), $urandom()};
    req_alpha  = FW'($urandom());
    req_beta   = FW'($urandom());
    if ($urandom_range(0, 7) == 0) begin
      req_alpha = '0;
      req_beta  = '0;
    end
    if ($urandom_range(0, 7) == 0) begin
      for (int k = 1; k < 4; k++) req_texels[k * NC * CW +: NC * CW] = req_texels[NC * CW - 1:0];
    end
    b64       = {$urandom(), $urandom()};
    req_bias  = b64[QW-1:0];
    req_tag   = tag;
    req_valid = 1'b1;
  endtask

  task automatic send_req(input logic [TW-1:0] tag);
    int cnt;
    rand_req(tag);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!req_ready && cnt < 200);
    if (cnt >= 200) check_eq("req_ready_timeout", 64'(req_ready), 64'(1));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int cnt;
    cnt = 0;
    while ((exp_q.size() != 0 || rsp_valid) && cnt < 1000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check_eq("drain_in_time", 64'(cnt < 1000), 64'(1));
  endtask

  // Single request into an idle pipe with rsp_ready high; checks latency and ch0.
  task automatic send_one(input string name, input logic [XW-1:0] tx, input logic [FW-1:0] a,
                          input logic [FW-1:0] b, input logic [QW-1:0] bias,
                          input logic [TW-1:0] tag, input logic [RW-1:0] exp_ch0);
    int cnt;
    req_texels = tx;
    req_alpha  = a;
    req_beta   = b;
    req_bias   = bias;
    req_tag    = tag;
    req_valid  = 1'b1;
    @(negedge clk);
    check_eq({name, "_ready"}, 64'(req_ready), 64'(1));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cnt = 1;
    while (!rsp_valid && cnt < 10) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check_eq({name, "_latency"}, 64'(cnt), 64'(3));
    check_eq({name, "_ch0"}, 64'(rsp_data[RW-1:0]), 64'(exp_ch0));
    check_eq({name, "_tag"}, 64'(rsp_tag), 64'(tag));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [XW-1:0] tx;
    logic [QW-1:0] bias;
    logic [7:0]    val;
    logic          got;
    int            acc, base, stale;
    logic [TW-1:0] tag;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check_eq("rst_rsp_data", 64'(rsp_data), 64'(0));
    check_eq("rst_rsp_tag", 64'(rsp_tag), 64'(0));
    check_eq("rst_perf", 64'(perf_stalls), 64'(0));
    reset = 1'b0;
    #1;
    check_eq("rst_req_ready", 64'(req_ready), 64'(1));
    @(posedge clk);
    #1;

    // Directed vectors
    tx = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int k = 0; k < 4; k++) tx[(k * NC) * CW +: CW] = 8'h40;
    send_one("flat40", tx, 8'h80, 8'h80, '0, 8'hA1, 11'h040);

    tx = {$urandom(), $urandom(), $urandom(), $urandom()};
    tx[(T00 * NC) * CW +: CW] = 8'h00;
    tx[(T01 * NC) * CW +: CW] = 8'hFF;
    tx[(T10 * NC) * CW +: CW] = 8'h00;
    tx[(T11 * NC) * CW +: CW] = 8'hFF;
    bias = QW'({$urandom(), $urandom()});
    bias[BW-1:0] = 9'h100;
    send_one("half_bias", tx, 8'h80, 8'h00, bias, 8'hA2, BIAS_EN ? 11'h780 : 11'h080);

    tx = '1;
    bias = {NC{9'h0FF}};
    send_one("max_bias", tx, FW'($urandom()), FW'($urandom()), bias, 8'hA3,
             BIAS_EN ? 11'h1FE : 11'h0FF);

    tx = {$urandom(), $urandom(), $urandom(), $urandom()};
    val = tx[CW-1:0];
    send_one("frac_zero", tx, 8'h00, 8'h00, '0, 8'hA4, {3'b000, val});

    val = 8'($urandom());
    tx = '0;
    for (int k = 0; k < 4; k++) tx[(k * NC) * CW +: CW] = val;
    send_one("equal_tex", tx, FW'($urandom()), FW'($urandom()), '0, 8'hA5, {3'b000, val});

    // Back-to-back with rsp_ready toggling
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    base = rsp_seen;
    for (int i = 0; i < 10; i++) send_req(TW'(16 + i));
    wait_drain();
    check_eq("toggle_count", 64'(rsp_seen - base), 64'(10));
    check_eq("toggle_stalls", 64'(perf_stalls), 64'(model_stalls));

    // Full back-pressure: exactly three requests held
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    tag = 8'h40;
    rand_req(tag);
    acc = 0;
    repeat (8) begin
      @(negedge clk);
      got = req_ready;
      @(posedge clk);
      #1;
      if (got) begin
        acc++;
        tag++;
        rand_req(tag);
      end
    end
    req_valid = 1'b0;
    check_eq("bp_accepted", 64'(acc), 64'(3));
    check_eq("bp_ready_low", 64'(req_ready), 64'(0));
    rdy_mode = 0;
    wait_drain();
    check_eq("bp_ready_high", 64'(req_ready), 64'(1));
    check_eq("bp_stalls", 64'(perf_stalls), 64'(model_stalls));

    // Reset with two requests in flight
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send_req(8'h70);
    send_req(8'h71);
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check_eq("mid_rst_perf", 64'(perf_stalls), 64'(0));
    check_eq("mid_rst_req_ready", 64'(req_ready), 64'(1));
    @(posedge clk);
    #1;
    reset = 1'b0;
    rdy_mode = 0;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) stale++;
    end
    check_eq("no_stale_rsp", 64'(stale), 64'(0));

    // Random traffic with random back-pressure
    rdy_mode = 3;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end else begin
        send_req(TW'(i));
      end
    end
    rdy_mode = 0;
    wait_drain();
    check_eq("final_stalls", 64'(perf_stalls), 64'(model_stalls));
    check_eq("final_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
